// File: rtl/dmem_responder.sv
// dmem_responder: LSU data-memory responder with byte-masked word RAM, programmable wait states and range checking.
//   Ports: clk, rst (async, active-high); cs (active-low request), wr (1=read, 0=write),
//   mask[3:0] byte lanes, addr[31:0] byte address, data_wr[31:0] store data;
//   data_rd[31:0] read word, ready one-cycle completion pulse, err out-of-range flag (valid with ready).
//   Optional macro DMEM_ACCESS_CNT_EN adds saturating rd_count/wr_count outputs.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        ready,
  output logic        err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [29:0] off;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        access;
  logic [31:0] mem [DEPTH_WORDS];
  // Word offset only: BASE_ADDR is word aligned, so the low address bits never borrow.
  // The explicit >= test stops addresses below the base from wrapping into range.
  assign off      = addr_q[31:2] - BASE_ADDR[31:2];
  assign in_range = (addr_q >= BASE_ADDR) && (off < 30'(DEPTH_WORDS));
  assign idx      = off[AW-1:0];
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign data_rd  = data_rd_q;
  assign ready    = ready_q;
  assign err      = err_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_rd_d = data_rd_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: if (!cs) begin
        wr_d    = wr;
        mask_d  = mask;
        addr_d  = addr;
        wdata_d = data_wr;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d   = RESP;
        ready_d   = 1'b1;
        err_d     = !in_range;
        data_rd_d = wr_q ? (in_range ? mem[idx] : 32'd0) : data_rd_q;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      mask_q    <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      data_rd_q <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_rd_q <= data_rd_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end
  // RAM is not reset; a reset drops state_q to IDLE, which blocks any pending commit.
  always_ff @(posedge clk) begin
    if (access && !wr_q && in_range)
      for (int i = 0; i < 4; i++)
        if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if (access && in_range) begin
      if (wr_q && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (!wr_q && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (d0: no wait states, base 0; d1: 3 wait states, base 0x100).
module tb_dmem_responder;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  typedef struct packed {logic err; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic cs [2];
  logic wr [2];
  logic [3:0] mask [2];
  logic [31:0] addr [2];
  logic [31:0] dw [2];
  logic [31:0] dr [2];
  logic rdy [2];
  logic er [2];
  logic [31:0] lastrd [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rc0, wc0, rc1, wc1;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .cs(cs[0]), .wr(wr[0]), .mask(mask[0]), .addr(addr[0]),
    .data_wr(dw[0]), .data_rd(dr[0]), .ready(rdy[0]), .err(er[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rc0), .wr_count(wc0)
`endif
  );
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .WAIT_CYCLES(3)) d1 (
    .clk(clk), .rst(rst), .cs(cs[1]), .wr(wr[1]), .mask(mask[1]), .addr(addr[1]),
    .data_wr(dw[1]), .data_rd(dr[1]), .ready(rdy[1]), .err(er[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rdy[0] === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0 unexpected ready: got 1 expected 0");
      end else begin
        e = q0.pop_front();
        chk("d0 err", 32'(er[0]), 32'(e.err));
        chk("d0 data_rd", dr[0], e.data);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rdy[1] === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1 unexpected ready: got 1 expected 0");
      end else begin
        e = q1.pop_front();
        chk("d1 err", 32'(er[1]), 32'(e.err));
        chk("d1 data_rd", dr[1], e.data);
      end
    end
  end
  task automatic push(input int d, input logic e_err, input logic [31:0] e_data);
    exp_t x;
    x.err = e_err;
    x.data = e_data;
    if (d == 0) q0.push_back(x); else q1.push_back(x);
  endtask
  // Expected data_rd: reads update the tracked value, writes leave it alone.
  task automatic req(input int d, input logic w, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
    int k;
    bit seen;
    if (w == RD) lastrd[d] = e_rd;
    push(d, e_err, lastrd[d]);
    @(negedge clk);
    cs[d] = 1'b0; wr[d] = w; mask[d] = m; addr[d] = a; dw[d] = wd;
    @(posedge clk);
    #1 cs[d] = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      addr[d] = $urandom; dw[d] = $urandom; wr[d] = ~wr[d]; mask[d] = 4'($urandom);
      @(posedge clk);
      #1 seen = (rdy[d] === 1'b1);
      if (!seen) k++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL d%0d ready timeout: got none expected pulse", d);
    end else begin
      chk("ready latency", 32'(k), (d == 0) ? 32'd0 : 32'd3);
      @(posedge clk);
      #1 chk("ready pulse width", 32'(rdy[d]), 32'd0);
    end
  endtask
  task automatic chk_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("reset ready", 32'(rdy[d]), 32'd0);
      chk("reset err", 32'(er[d]), 32'd0);
      chk("reset data_rd", dr[d], 32'd0);
    end
  endtask
  initial begin
    int t0, t1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b1; wr[d] = 1'b0; mask[d] = 4'd0; addr[d] = 32'd0; dw[d] = 32'd0; lastrd[d] = 32'd0;
    end
    #2 chk_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    // d0: basic write/read and byte masking
    req(0, WR, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    req(0, RD, 4'b0000, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    req(0, WR, 4'b0010, 32'h11, 32'h0000AA00, 1'b0, 32'h0);
    req(0, RD, 4'b0001, 32'h10, 32'h0, 1'b0, 32'hDEADAAEF);
    req(0, WR, 4'b1100, 32'h12, 32'h12340000, 1'b0, 32'h0);
    req(0, RD, 4'b1111, 32'h10, 32'h0, 1'b0, 32'h1234AAEF);
    // d0: out of range and zero mask
    req(0, RD, 4'b1111, 32'h1000, 32'h0, 1'b1, 32'h0);
    req(0, WR, 4'b1111, 32'h0, 32'h11223344, 1'b0, 32'h0);
    req(0, WR, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
    req(0, RD, 4'b1111, 32'h0, 32'h0, 1'b0, 32'h11223344);
    req(0, WR, 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    req(0, RD, 4'b1111, 32'h0, 32'h0, 1'b0, 32'h11223344);
    req(0, WR, 4'b1111, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    req(0, RD, 4'b1111, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
    req(0, RD, 4'b1111, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0);
    // d1: base 0x100, three wait states
    req(1, RD, 4'b1111, 32'hFC, 32'h0, 1'b1, 32'h0);
    req(1, WR, 4'b1111, 32'h100, 32'hA5A5A5A5, 1'b0, 32'h0);
    req(1, RD, 4'b1111, 32'h100, 32'h0, 1'b0, 32'hA5A5A5A5);
    req(1, WR, 4'b1111, 32'h10FC, 32'h5A5A0FF0, 1'b0, 32'h0);
    req(1, RD, 4'b0000, 32'h10FC, 32'h0, 1'b0, 32'h5A5A0FF0);
    req(1, RD, 4'b1111, 32'h1100, 32'h0, 1'b1, 32'h0);
    req(1, RD, 4'b1111, 32'h100, 32'h0, 1'b0, 32'hA5A5A5A5);
    // d1: reset aborts a write in flight
    @(negedge clk);
    cs[1] = 1'b0; wr[1] = WR; mask[1] = 4'b1111; addr[1] = 32'h100; dw[1] = 32'h0BADF00D;
    @(posedge clk);
    #1 cs[1] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    lastrd[0] = 32'd0; lastrd[1] = 32'd0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("aborted ready", 32'(rdy[1]), 32'd0);
    req(1, RD, 4'b1111, 32'h100, 32'h0, 1'b0, 32'hA5A5A5A5);
    // d1: cs held low through RESP is re-accepted
    push(1, 1'b0, 32'hA5A5A5A5);
    push(1, 1'b0, 32'hA5A5A5A5);
    @(negedge clk);
    cs[1] = 1'b0; wr[1] = RD; mask[1] = 4'b0000; addr[1] = 32'h100;
    t0 = -1; t1 = -1;
    for (int k = 0; k < 40 && t1 < 0; k++) begin
      @(posedge clk);
      #1;
      if (rdy[1] === 1'b1) begin
        if (t0 < 0) t0 = cyc; else t1 = cyc;
      end
      if (t0 >= 0 && cyc == t0 + 2) cs[1] = 1'b1;
    end
    cs[1] = 1'b1;
    if (t1 < 0) begin
      checks++; errors++;
      $display("FAIL re-accept timeout: got %0d pulses expected 2", (t0 < 0) ? 0 : 1);
    end else chk("re-accept spacing", 32'(t1 - t0), 32'd6);
    repeat (8) @(posedge clk);
`ifdef DMEM_ACCESS_CNT_EN
    @(negedge clk) rst = 1'b1;
    #1 chk("rd_count reset", rc0, 32'd0);
    chk("wr_count reset", wc0, 32'd0);
    lastrd[0] = 32'd0; lastrd[1] = 32'd0;
    @(negedge clk) rst = 1'b0;
    req(0, WR, 4'b1111, 32'h20, 32'h00000001, 1'b0, 32'h0);
    req(0, WR, 4'b0000, 32'h24, 32'h0, 1'b0, 32'h0);
    req(0, RD, 4'b1111, 32'h20, 32'h0, 1'b0, 32'h00000001);
    req(0, RD, 4'b1111, 32'h20, 32'h0, 1'b0, 32'h00000001);
    req(0, RD, 4'b1111, 32'h10, 32'h0, 1'b0, 32'h1234AAEF);
    req(0, RD, 4'b1111, 32'h1000, 32'h0, 1'b1, 32'h0);
    chk("wr_count", wc0, 32'd2);
    chk("rd_count", rc0, 32'd3);
    @(negedge clk) rst = 1'b1;
    #1 chk("rd_count cleared", rc0, 32'd0);
    chk("wr_count cleared", wc0, 32'd0);
    @(negedge clk) rst = 1'b0;
`endif
    repeat (2) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
